// File: rtl/pio_mailbox_pkg.sv
// Shared definitions for the PIO command mailbox responder: opcodes, FSM states,
// command/response bit positions and a response-word packing helper.
package pio_mailbox_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_ADD   = 3'd3,
        OP_DELAY = 3'd4,
        OP_CNT   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_RESP
    } fsm_e;

    localparam int CMD_REQ     = 31;
    localparam int CMD_OP_HI   = 30;
    localparam int CMD_OP_LO   = 28;
    localparam int CMD_ADDR_HI = 27;
    localparam int CMD_ADDR_LO = 24;
    localparam int CMD_DATA_HI = 15;

    localparam int RSP_ACK  = 31;
    localparam int RSP_BUSY = 30;
    localparam int RSP_ERR  = 29;

    function automatic logic [31:0] pack_rsp(input logic ack, input logic busy,
                                             input logic err, input logic [15:0] rdata);
        logic [31:0] w;
        w           = '0;
        w[RSP_ACK]  = ack;
        w[RSP_BUSY] = busy;
        w[RSP_ERR]  = err;
        w[15:0]     = rdata;
        return w;
    endfunction

endpackage

// File: rtl/pio_mailbox_regfile.sv
// Mailbox register file: one synchronous write port, one combinational read port,
// and the whole array exported as a flat bus with register 0 in the LSBs.
module pio_mailbox_regfile #(
    parameter int REG_COUNT = 16,
    parameter int DATA_W    = 16,
    parameter int AW        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [AW-1:0]               waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [AW-1:0]               raddr,
    output logic [DATA_W-1:0]           rdata,
    output logic [REG_COUNT*DATA_W-1:0] reg_bus
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // NOTE: this array is reset because software may read any register right after
    // reset; a plain RAM without reset would need its contents treated as unknown.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

    always_comb begin
        reg_bus = '0;
        for (int i = 0; i < REG_COUNT; i++) reg_bus[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: rtl/pio_mailbox_responder.sv
// Responder end of the PIO command mailbox: decodes toggle-handshake commands from
// pio_out, executes them on a local register file and cycle counter, answers on pio_in.
module pio_mailbox_responder
    import pio_mailbox_pkg::*;
#(
    parameter int REG_COUNT = 16,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 32
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [31:0]                 pio_out_export,
    output logic [31:0]                 pio_in_export,
    output logic                        done_pulse,
    output logic [REG_COUNT*DATA_W-1:0] reg_bus
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    fsm_e              state_q, state_d;
    logic [31:0]       cmd_q;
    logic              req_q;
    logic [2:0]        op_q;
    logic [3:0]        addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] delay_q;
    logic              ack_q, busy_q, err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pending, addr_ok, wr_en, exec_err;
    logic [DATA_W-1:0] rd_data, sum, wr_data, exec_data;

    assign pending = (cmd_q[CMD_REQ] != ack_q);
    assign addr_ok = (32'(addr_q) < 32'(REG_COUNT));
    assign sum     = rd_data + data_q;

    pio_mailbox_regfile #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .AW        (AW)
    ) u_regfile (
        .clk     (clk_clk),
        .reset   (reset_reset),
        .we      (wr_en),
        .waddr   (addr_q[AW-1:0]),
        .wdata   (wr_data),
        .raddr   (addr_q[AW-1:0]),
        .rdata   (rd_data),
        .reg_bus (reg_bus)
    );

    // NOTE: every output of this block gets a default before the case so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        exec_data = '0;
        exec_err  = 1'b0;

        case (op_q)
            OP_NOP, OP_DELAY: ;
            OP_WRITE: begin
                if (addr_ok) begin
                    wr_en     = 1'b1;
                    wr_data   = data_q;
                    exec_data = data_q;
                end else exec_err = 1'b1;
            end
            OP_READ: begin
                if (addr_ok) exec_data = rd_data;
                else         exec_err  = 1'b1;
            end
            OP_ADD: begin
                if (addr_ok) begin
                    wr_en     = 1'b1;
                    wr_data   = sum;
                    exec_data = sum;
                end else exec_err = 1'b1;
            end
            OP_CNT:  exec_data = cnt_q[DATA_W-1:0];
            default: exec_err  = 1'b1;
        endcase
        if (state_q != S_EXEC) wr_en = 1'b0;

        case (state_q)
            S_IDLE: if (pending) state_d = S_EXEC;
            S_EXEC: state_d = (op_q == OP_DELAY && data_q != '0) ? S_WAIT : S_RESP;
            S_WAIT: if (delay_q == DATA_W'(1)) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values and the block's ordering does not matter.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            delay_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= pio_out_export;
            cnt_q   <= cnt_q + 1'b1;

            if (state_q == S_IDLE && pending) begin
                req_q  <= cmd_q[CMD_REQ];
                op_q   <= cmd_q[CMD_OP_HI:CMD_OP_LO];
                addr_q <= cmd_q[CMD_ADDR_HI:CMD_ADDR_LO];
                data_q <= cmd_q[DATA_W-1:0];
                busy_q <= 1'b1;
            end

            if (state_q == S_EXEC) delay_q <= data_q;
            if (state_q == S_WAIT) delay_q <= delay_q - 1'b1;

            // The response becomes visible in the RESP cycle itself; a DELAY reaching
            // RESP through WAIT always answers with zero data and no error.
            if (state_d == S_RESP && state_q != S_RESP) begin
                ack_q   <= req_q;
                busy_q  <= 1'b0;
                rdata_q <= (state_q == S_WAIT) ? '0 : exec_data;
                err_q   <= (state_q == S_WAIT) ? 1'b0 : exec_err;
            end
        end
    end

    assign pio_in_export = pack_rsp(ack_q, busy_q, err_q, rdata_q[15:0]);
    assign done_pulse    = (state_q == S_RESP);

endmodule

// File: tb/tb_pio_mailbox_responder.sv
// Directed self-checking bench for pio_mailbox_responder (8-register build so the
// out-of-range address path is reachable).
module tb_pio_mailbox_responder;

    localparam int REG_COUNT = 8;
    localparam int DATA_W    = 16;

    logic                        clk;
    logic                        rst;
    logic [31:0]                 pio_out;
    logic [31:0]                 pio_in;
    logic                        done;
    logic [REG_COUNT*DATA_W-1:0] reg_bus;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic [15:0] c1;
    logic [15:0] m_regs [REG_COUNT];

    pio_mailbox_responder #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W),
        .CNT_W     (32)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .pio_out_export (pio_out),
        .pio_in_export  (pio_in),
        .done_pulse     (done),
        .reg_bus        (reg_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_COUNT*DATA_W-1:0] model_bus();
        logic [REG_COUNT*DATA_W-1:0] b;
        for (int i = 0; i < REG_COUNT; i++) b[i*DATA_W +: DATA_W] = m_regs[i];
        return b;
    endfunction

    // Steps negedges until ACK equals req; lat = cycles taken, or -1 on timeout.
    task automatic wait_ack(input logic req, input int limit, output int l);
        l = 0;
        while (l < limit) begin
            @(negedge clk);
            l++;
            if (pio_in[31] === req) return;
        end
        l = -1;
    endtask

    task automatic send(input string tag, input logic [31:0] word, input int exp_lat,
                        input logic [31:0] exp_rsp);
        int l;
        pio_out = word;
        wait_ack(word[31], 200, l);
        check({tag, "_lat"}, 128'(l), 128'(exp_lat));
        check({tag, "_rsp"}, 128'(pio_in), 128'(exp_rsp));
        check({tag, "_done"}, 128'(done), 128'(1'b1));
    endtask

    initial begin
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
        rst     = 1'b1;
        pio_out = '0;
        repeat (3) @(negedge clk);
        check("reset_rsp", 128'(pio_in), 128'(32'h0));
        check("reset_done", 128'(done), 128'(1'b0));
        check("reset_regs", 128'(reg_bus), 128'(model_bus()));
        rst = 1'b0;

        // Write then read back register 3.
        send("wr3", 32'h9300_1234, 3, 32'h8000_1234);
        m_regs[3] = 16'h1234;
        @(negedge clk);
        check("wr3_done_clear", 128'(done), 128'(1'b0));
        check("wr3_bus", 128'(reg_bus[63:48]), 128'(16'h1234));
        send("rd3", 32'h2300_0000, 3, 32'h0000_1234);

        // Add wraps modulo 2^16.
        send("wr0", 32'h9000_FFFF, 3, 32'h8000_FFFF);
        m_regs[0] = 16'hFFFF;
        send("add0", 32'h3000_0002, 3, 32'h0000_0001);
        m_regs[0] = 16'h0001;
        @(negedge clk);
        check("add0_bus", 128'(reg_bus), 128'(model_bus()));

        // DELAY 5: BUSY during cycles 2..7, ACK and done at cycle 8 only.
        pio_out = 32'hC000_0005;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            check($sformatf("dly5_busy_c%0d", cyc), 128'(pio_in[30]),
                  128'((cyc >= 2 && cyc <= 7) ? 1'b1 : 1'b0));
            check($sformatf("dly5_ack_c%0d", cyc), 128'(pio_in[31]),
                  128'((cyc >= 8) ? 1'b1 : 1'b0));
            check($sformatf("dly5_done_c%0d", cyc), 128'(done),
                  128'((cyc == 8) ? 1'b1 : 1'b0));
        end
        check("dly5_rdata", 128'(pio_in[15:0]), 128'(16'h0));

        // Back-to-back CNT: EXEC cycles are exactly 3 apart.
        pio_out = 32'h5000_0000;
        wait_ack(1'b0, 20, lat);
        check("cnt1_lat", 128'(lat), 128'(3));
        c1 = pio_in[15:0];
        pio_out = 32'hD000_0000;
        wait_ack(1'b1, 20, lat);
        check("cnt2_lat", 128'(lat), 128'(3));
        check("cnt2_hdr", 128'(pio_in[31:16]), 128'(16'h8000));
        check("cnt_delta", 128'(16'(pio_in[15:0] - c1)), 128'(16'd3));

        // Error cases leave registers alone; next success clears ERR.
        send("op7", 32'h7000_0000, 3, 32'h2000_0000);
        send("rd15", 32'hAF00_0000, 3, 32'hA000_0000);
        send("wr9", 32'h1900_BEEF, 3, 32'h2000_0000);
        @(negedge clk);
        check("err_regs", 128'(reg_bus), 128'(model_bus()));
        send("nop", 32'h8000_0000, 3, 32'h8000_0000);

        // Command change during BUSY with REQ==ACK afterwards is never executed.
        pio_out = 32'h4000_0064;
        repeat (10) @(negedge clk);
        check("dly100_busy", 128'(pio_in[30]), 128'(1'b1));
        pio_out = 32'h1100_DEAD;
        wait_ack(1'b0, 200, lat);
        check("dly100_lat", 128'(lat), 128'(93));
        check("dly100_rsp", 128'(pio_in), 128'(32'h0000_0000));
        repeat (6) @(negedge clk);
        check("dly100_idle_rsp", 128'(pio_in), 128'(32'h0000_0000));
        check("dly100_regs", 128'(reg_bus), 128'(model_bus()));

        // A re-toggled REQ seen during BUSY starts a new command after ACK.
        pio_out = 32'hC000_0014;
        repeat (5) @(negedge clk);
        pio_out = 32'h1100_BEEF;
        wait_ack(1'b1, 200, lat);
        check("dly20_lat", 128'(lat), 128'(18));
        check("dly20_rsp", 128'(pio_in), 128'(32'h8000_0000));
        wait_ack(1'b0, 20, lat);
        check("follow_lat", 128'(lat), 128'(3));
        check("follow_rsp", 128'(pio_in), 128'(32'h0000_BEEF));
        m_regs[1] = 16'hBEEF;
        @(negedge clk);
        check("follow_regs", 128'(reg_bus), 128'(model_bus()));

        // Reset during a DELAY aborts; a pending REQ at release executes.
        pio_out = 32'hC000_0032;
        repeat (10) @(negedge clk);
        check("dly50_busy", 128'(pio_in[30]), 128'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
        check("midrst_rsp", 128'(pio_in), 128'(32'h0));
        check("midrst_done", 128'(done), 128'(1'b0));
        check("midrst_regs", 128'(reg_bus), 128'(model_bus()));
        pio_out = 32'h9200_00AA;
        @(negedge clk);
        rst = 1'b0;
        wait_ack(1'b1, 20, lat);
        check("postrst_lat", 128'(lat), 128'(3));
        check("postrst_rsp", 128'(pio_in), 128'(32'h8000_00AA));
        m_regs[2] = 16'h00AA;
        @(negedge clk);
        check("postrst_regs", 128'(reg_bus), 128'(model_bus()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
